multiport_rf_sb: RTL

MULTIPORT_RF_SB -- requirements
Module: multiport_rf_sb

---
 rtl/multiport_rf_sb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multiport_rf_sb.sv
`default_nettype none
// ============================================================================
//  Module   : multiport_rf_sb
//  Purpose  : Multi-ported register file with an integrated busy-bit
//             scoreboard. Entry 0 is hardwired to zero and is never busy.
//             Reads are combinational. Writes land at the rising edge, and
//             the highest-index port wins an address collision. Issue
//             strobes set busy bits, writebacks clear them, and if both hit
//             the same entry in one cycle the issue wins. Flush clears every
//             busy bit.
//  Optional : MULTIPORT_RF_SB_BYPASS_EN. When this macro is defined, a
//             same-cycle write is forwarded to the matching read ports, and
//             that forwarded write also makes the operand ready.
//  Ports    : clk, rst (sync, active-high)
//             raddr/rdata/rready  - NUM_RD read ports, port k at slice k
//             we/waddr/wdata      - NUM_WR write (writeback) ports
//             iss_valid/iss_addr  - NUM_WR destination-issue ports
//             flush               - clear all busy bits
//             busy_cnt            - registered popcount of busy bits
//  Revision : 1.0 - initial release
// ============================================================================
module multiport_rf_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 5,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rready,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_WR-1:0]            iss_valid,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] iss_addr,
  input  logic                         flush,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]    r_busy;
  logic [ADDR_WIDTH:0]   r_busy_cnt;

  logic [c_DEPTH-1:0]    w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_busy_cnt_nxt;

  // Next busy vector: clears first, then sets, so an issue overrides a
  // completing writeback to the same entry. Flush overrides everything.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j]) begin
        w_busy_nxt[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (iss_valid[j]) begin
        w_busy_nxt[iss_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    // Entry 0 can never be busy, which also caps the count at DEPTH-1.
    w_busy_nxt[0] = 1'b0;
  end

  // The count is taken from the next-state vector so the registered value
  // matches the busy bits it describes on the same edge.
  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < c_DEPTH; i++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + {{ADDR_WIDTH{1'b0}}, w_busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      // Ascending loop order: a later (higher-index) port overwrites the
      // earlier ones that target the same address.
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
          r_mem[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign busy_cnt = r_busy_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0] w_rd;
    logic                  w_hit;

    assign w_ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_rd  = r_mem[w_ra];
      w_hit = 1'b0;
`ifdef MULTIPORT_RF_SB_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == w_ra) && (w_ra != '0)) begin
          w_rd  = wdata[j*DATA_WIDTH +: DATA_WIDTH];
          w_hit = 1'b1;
        end
      end
`endif
      if (w_ra == '0) begin
        w_rd = '0;
      end
    end

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
    assign rready[k] = (w_ra == '0) | ~r_busy[w_ra] | w_hit;
  end

endmodule
`default_nettype wire
